// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if -- fetch-control bundle between pipeline control and pc_gen.
//
// Parameter:
//   ADDR_W      width of every address signal in the bundle
//
// Signals (direction as seen by pc_gen, i.e. the slave modport):
//   stall       in   hold the PC (pipeline stall)
//   flush       in   exception/flush redirect strobe
//   flush_pc    in   flush handler address, sampled with flush
//   br_flag     in   taken-branch strobe from decode
//   br_target   in   branch target, sampled with br_flag
//   ce          out  instruction-memory chip enable
//   pc          out  current fetch address
//   pend_valid  out  a branch target is parked until the stall releases
//   misalign    out  one-cycle pulse: a redirect target was rejected
//   bad_addr    out  last rejected redirect target
// ---------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              br_flag;
    logic [ADDR_W-1:0] br_target;
    logic              ce;
    logic [ADDR_W-1:0] pc;
    logic              pend_valid;
    logic              misalign;
    logic [ADDR_W-1:0] bad_addr;

    // Pipeline control side.
    modport master (
        output stall, flush, flush_pc, br_flag, br_target,
        input  ce, pc, pend_valid, misalign, bad_addr
    );

    // PC generator side.
    modport slave (
        input  stall, flush, flush_pc, br_flag, br_target,
        output ce, pc, pend_valid, misalign, bad_addr
    );
endinterface

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- instruction fetch program-counter generator.
//
// Produces one sequential fetch address per unstalled cycle and redirects on
// flush or taken branch. A branch that arrives while the pipeline is stalled
// is parked and applied on the first unstalled edge. Redirect priority on
// every edge: flush > branch > stall > parked branch > increment.
//
// Parameters:
//   ADDR_W     PC / address width
//   RESET_VEC  first fetch address after reset
//   INC        sequential increment
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   bus        pc_gen_if.slave (stall/flush/branch in; ce/pc/status out)
//
// Build option:
//   PC_MISALIGN_TRAP_EN  when defined, redirect targets with addr[1:0] != 0
//                        are dropped (as if the strobe were absent), misalign
//                        pulses and bad_addr records the target. When not
//                        defined, every target is accepted and misalign /
//                        bad_addr are tied to 0.
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       INC       = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RUN       = 2'd1,
        HOLD      = 2'd2,
        HOLD_PEND = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;

    // Qualified strobes: a rejected target behaves as if its strobe were low,
    // so lower-priority rules still get to act on that edge.
    logic flush_ok;
    logic br_ok;

`ifdef PC_MISALIGN_TRAP_EN
    logic              flush_rej;
    logic              br_rej;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] bad_q, bad_d;

    assign flush_rej = bus.flush && (bus.flush_pc[1:0] != 2'b00);
    assign flush_ok  = bus.flush && !flush_rej;
    // A branch is only looked at (and so only rejected) when no flush wins.
    assign br_rej    = bus.br_flag && !flush_ok && (bus.br_target[1:0] != 2'b00);
    assign br_ok     = bus.br_flag && (bus.br_target[1:0] == 2'b00);

    always_comb begin
        misalign_d = 1'b0;
        bad_d      = bad_q;
        // Nothing is evaluated while the generator is off.
        if (state_q != OFF && (flush_rej || br_rej)) begin
            misalign_d = 1'b1;
            bad_d      = flush_rej ? bus.flush_pc : bus.br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
            bad_q      <= '0;
        end else begin
            misalign_q <= misalign_d;
            bad_q      <= bad_d;
        end
    end

    assign bus.misalign = misalign_q;
    assign bus.bad_addr = bad_q;
`else
    assign flush_ok     = bus.flush;
    assign br_ok        = bus.br_flag;
    assign bus.misalign = 1'b0;
    assign bus.bad_addr = '0;
`endif

    // NOTE: every output of this block is given a default before the case so
    // that no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            OFF: begin
                // Strobes are ignored here; fetch starts at RESET_VEC.
                state_d = RUN;
                pc_d    = RESET_VEC;
            end
            default: begin
                if (flush_ok) begin
                    pc_d    = bus.flush_pc;
                    state_d = bus.stall ? HOLD : RUN;
                end else if (br_ok) begin
                    if (bus.stall) begin
                        // Newest branch during a stall overwrites any parked one.
                        pend_d  = bus.br_target;
                        state_d = HOLD_PEND;
                    end else begin
                        pc_d    = bus.br_target;
                        state_d = RUN;
                    end
                end else if (bus.stall) begin
                    // HOLD and HOLD_PEND keep their state; RUN starts holding.
                    if (state_q == RUN) state_d = HOLD;
                end else if (state_q == HOLD_PEND) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end else begin
                    // Wraps modulo 2**ADDR_W by design.
                    pc_d    = pc_q + ADDR_W'(INC);
                    state_d = RUN;
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            ce_q    <= 1'b0;
            pc_q    <= RESET_VEC;
            // NOTE: the parked target is reset too, so a stale value can never
            // be observed even though pend_valid already guards it.
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= 1'b1;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.ce         = ce_q;
    assign bus.pc         = pc_q;
    assign bus.pend_valid = (state_q == HOLD_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (ADDR_W=32, RESET_VEC=0, INC=4).
//
// Directed scenarios (reset release, stalled branch, simultaneous events, wrap,
// reset while a branch is parked, misaligned target, strobes while off)
// followed by randomized traffic. Expected outputs come from a behavioural
// model that tracks only "off", pc, and an optional parked target.
// Honours PC_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32)) bus ();

    pc_gen #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0),
        .INC      (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit          m_off = 1'b1;
    logic [31:0] m_pc  = 32'h0;
    bit          m_pv  = 1'b0;
    logic [31:0] m_pt  = 32'h0;
    bit          m_mis = 1'b0;
    logic [31:0] m_bad = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare everything.
    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] fp,
                        input bit b, input logic [31:0] bt);
        bit fl, br;
        rst           = r;
        bus.stall     = s;
        bus.flush     = f;
        bus.flush_pc  = fp;
        bus.br_flag   = b;
        bus.br_target = bt;
        @(posedge clk);
        fl    = f;
        br    = b;
        m_mis = 1'b0;
        if (r) begin
            m_off = 1'b1; m_pc = 32'h0; m_pv = 1'b0; m_bad = 32'h0;
        end else if (m_off) begin
            m_off = 1'b0;
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            if (f && fp[1:0] != 2'b00) begin
                fl = 1'b0; m_mis = 1'b1; m_bad = fp;
            end
            if (!fl && b && bt[1:0] != 2'b00) begin
                br = 1'b0;
                if (!m_mis) m_bad = bt;
                m_mis = 1'b1;
            end
`endif
            if (fl) begin
                m_pc = fp; m_pv = 1'b0;
            end else if (br) begin
                if (s) begin m_pv = 1'b1; m_pt = bt; end
                else   begin m_pc = bt; m_pv = 1'b0; end
            end else if (s) begin
                // hold
            end else if (m_pv) begin
                m_pc = m_pt; m_pv = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        check("ce",         {31'b0, bus.ce},         {31'b0, !m_off});
        check("pc",         bus.pc,                  m_pc);
        check("pend_valid", {31'b0, bus.pend_valid}, {31'b0, m_pv});
        check("misalign",   {31'b0, bus.misalign},   {31'b0, m_mis});
        check("bad_addr",   bus.bad_addr,            m_bad);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] fp, bt;
        bit s, f, b, r;

        // Reset release.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_ce", {31'b0, bus.ce}, 32'd0);
        check("rst_pc", bus.pc, 32'h0);
        idle();
        check("rel_ce", {31'b0, bus.ce}, 32'd1);
        check("rel_pc0", bus.pc, 32'h0);
        idle(); check("rel_pc4", bus.pc, 32'h4);
        idle(); check("rel_pc8", bus.pc, 32'h8);
        idle(); idle();
        check("at_10", bus.pc, 32'h10);

        // Stall for three cycles, branch to 0x80 in the second.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_pc", bus.pc, 32'h10);
        check("stall_pv", {31'b0, bus.pend_valid}, 32'd1);
        idle();
        check("pend_pc", bus.pc, 32'h80);
        check("pend_pv", {31'b0, bus.pend_valid}, 32'd0);
        idle(); check("pend_next", bus.pc, 32'h84);

        // Flush, branch and stall together.
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80);
        check("sim_pc", bus.pc, 32'h200);
        check("sim_pv", {31'b0, bus.pend_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("sim_hold", bus.pc, 32'h200);
        idle(); check("sim_next", bus.pc, 32'h204);

        // Wrap from the top of the address space.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle();
        check("wrap_pc", bus.pc, 32'h0);
        check("wrap_mis", {31'b0, bus.misalign}, 32'd0);

        // Reset while a branch to 0x40 is parked.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rp_pc", bus.pc, 32'h0);
        check("rp_pv", {31'b0, bus.pend_valid}, 32'd0);
        idle(); idle();
        check("rp_no40", bus.pc, 32'h4);
        idle(); check("rp_8", bus.pc, 32'h8);

        // Misaligned branch target at pc=0x20.
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", bus.pc, 32'h24);
        check("mis_flag", {31'b0, bus.misalign}, 32'd1);
        check("mis_bad", bus.bad_addr, 32'h102);
`else
        check("mis_pc", bus.pc, 32'h102);
        check("mis_flag", {31'b0, bus.misalign}, 32'd0);
`endif
        idle();
        check("mis_pulse", {31'b0, bus.misalign}, 32'd0);

        // Strobes are ignored on the release edge out of reset.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h400);
        check("off_pc", bus.pc, 32'h0);
        check("off_pv", {31'b0, bus.pend_valid}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 35);
            f  = ($urandom_range(0, 99) < 6);
            b  = ($urandom_range(0, 99) < 15);
            fp = $urandom();
            bt = $urandom();
            if ($urandom_range(0, 3) != 0) fp[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            step(1'b0 | r, s, f, fp, b, bt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
